// File: rtl/uart_command_parser_pkg.sv
// rtl/uart_command_parser_pkg.sv - shared UART/parser constants, state encoding and helpers
package uart_command_parser_pkg;

    localparam int CLOCK_FREQUENCY = 10_000_000;
    localparam int BAUD_RATE       = 115_200;
    localparam int CLOCKS_PER_BIT  = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int FRAME_LENGTH    = 2;

    localparam logic [7:0] CMD_READ_TEMP  = 8'h01;
    localparam logic [7:0] CMD_READ_HUMID = 8'h02;
    localparam logic [7:0] CMD_STATUS     = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ADDR = 2'd1,
        ST_PENDING   = 2'd2
    } parser_state_e;

    // Guard against a zero-width timer for degenerate timeout values.
    function automatic int timer_width(input int clocks);
        return (clocks > 1) ? $clog2(clocks) : 1;
    endfunction

endpackage

// File: rtl/uart_command_parser.sv
// rtl/uart_command_parser.sv - assembles 2-byte host requests from UART_RX into a valid/ready stream
module uart_command_parser
    import uart_command_parser_pkg::*;
#(
    parameter int TIMEOUT_CLOCKS = 8680,
    parameter int NUM_SENSORS    = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       has_data,
    input  logic [7:0] data_received,
    output logic       command_valid,
    input  logic       command_ready,
    output logic [7:0] command_code,
    output logic [7:0] sensor_address,
    output logic       frame_error,
    output logic       overrun
);

    localparam int              TW         = timer_width(TIMEOUT_CLOCKS);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CLOCKS - 1);

    logic [1:0]    rst_sync_q;
    logic          rst_n_sync;
    parser_state_e state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    code_q, addr_q;
    logic          frame_error_q, frame_error_d;
    logic          overrun_q, overrun_d;
    logic          latch_code, latch_addr;
    logic          addr_ok, timed_out;

    // Reset asserts immediately but releases two clocks later, on a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_sync = rst_sync_q[1];

    assign addr_ok   = ({24'd0, data_received} < 32'(NUM_SENSORS));
    assign timed_out = (timer_q == TIMER_LAST);

    always_ff @(posedge clock or negedge rst_n_sync) begin
        if (!rst_n_sync) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (has_data) state_d = ST_WAIT_ADDR;
            end
            ST_WAIT_ADDR: begin
                // A byte arriving on the timeout cycle still counts as the address.
                if (has_data)       state_d = addr_ok ? ST_PENDING : ST_IDLE;
                else if (timed_out) state_d = ST_IDLE;
            end
            ST_PENDING: begin
                if (command_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        command_valid = (state_q == ST_PENDING);
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;
        latch_code    = 1'b0;
        latch_addr    = 1'b0;
        timer_d       = '0;
        case (state_q)
            ST_IDLE: latch_code = has_data;
            ST_WAIT_ADDR: begin
                timer_d       = timed_out ? timer_q : timer_q + 1'b1;
                latch_addr    = has_data && addr_ok;
                frame_error_d = has_data ? !addr_ok : timed_out;
            end
            ST_PENDING: overrun_d = has_data;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            timer_q       <= '0;
            code_q        <= 8'd0;
            addr_q        <= 8'd0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
            if (latch_code) code_q <= data_received;
            if (latch_addr) addr_q <= data_received;
        end
    end

    assign command_code   = code_q;
    assign sensor_address = addr_q;
    assign frame_error    = frame_error_q;
    assign overrun        = overrun_q;

endmodule
